// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between two start/active requesters, the bus arbiter and the CPU bus master port.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding system.
interface cpu_bus_arbiter_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic          m0_start;
    logic [aw-1:0] m0_address;
    logic [3:0]    m0_selection;
    logic          m0_write;
    logic [dw-1:0] m0_data_wr;
    logic          m0_active;
    logic [dw-1:0] m0_data_rd;

    logic          m1_start;
    logic [aw-1:0] m1_address;
    logic [3:0]    m1_selection;
    logic          m1_write;
    logic [dw-1:0] m1_data_wr;
    logic          m1_active;
    logic [dw-1:0] m1_data_rd;

    logic          cpu_start;
    logic [aw-1:0] cpu_address;
    logic [3:0]    cpu_selection;
    logic          cpu_write;
    logic [dw-1:0] cpu_data_wr;
    logic          cpu_active;
    logic [dw-1:0] cpu_data_rd;

    logic [1:0]    grant;
    logic          timeout_err;

    modport slave (
        input  m0_start, m0_address, m0_selection, m0_write, m0_data_wr,
        output m0_active, m0_data_rd,
        input  m1_start, m1_address, m1_selection, m1_write, m1_data_wr,
        output m1_active, m1_data_rd,
        output cpu_start, cpu_address, cpu_selection, cpu_write, cpu_data_wr,
        input  cpu_active, cpu_data_rd,
        output grant, timeout_err
    );

    modport master (
        output m0_start, m0_address, m0_selection, m0_write, m0_data_wr,
        input  m0_active, m0_data_rd,
        output m1_start, m1_address, m1_selection, m1_write, m1_data_wr,
        input  m1_active, m1_data_rd,
        input  cpu_start, cpu_address, cpu_selection, cpu_write, cpu_data_wr,
        output cpu_active, cpu_data_rd,
        input  grant, timeout_err
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one CPU bus master port between two start/active requesters;
// routes completion and read data back to the owner and aborts requests the bus never accepts.
module cpu_bus_arbiter #(
    parameter int            dw         = 32,
    parameter int            aw         = 32,
    parameter int unsigned   TIMEOUT    = 255,
    parameter logic [dw-1:0] ABORT_DATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst,
    cpu_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, ABORT, DONE} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t        state, state_d;
    logic          owner, owner_d;
    logic          last_grant, last_grant_d;
    logic          pick;
    logic [15:0]   timer, timer_d;

    logic          cpu_start_q, cpu_start_d;
    logic [aw-1:0] cpu_address_q, cpu_address_d;
    logic [3:0]    cpu_selection_q, cpu_selection_d;
    logic          cpu_write_q, cpu_write_d;
    logic [dw-1:0] cpu_data_wr_q, cpu_data_wr_d;

    logic [1:0]    active_q, active_d;
    logic [dw-1:0] m0_data_rd_q, m0_data_rd_d;
    logic [dw-1:0] m1_data_rd_q, m1_data_rd_d;
    logic [1:0]    grant_q, grant_d;
    logic          timeout_err_q, timeout_err_d;

    // A lone requester wins outright; a tie goes to whichever side did not own the bus last.
    always_comb begin
        pick = bus.m1_start;
        if (bus.m0_start && bus.m1_start) begin
            pick = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            timer           <= '0;
            cpu_start_q     <= 1'b0;
            cpu_address_q   <= '0;
            cpu_selection_q <= '0;
            cpu_write_q     <= 1'b0;
            cpu_data_wr_q   <= '0;
            active_q        <= '0;
            m0_data_rd_q    <= '0;
            m1_data_rd_q    <= '0;
            grant_q         <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state           <= state_d;
            owner           <= owner_d;
            last_grant      <= last_grant_d;
            timer           <= timer_d;
            cpu_start_q     <= cpu_start_d;
            cpu_address_q   <= cpu_address_d;
            cpu_selection_q <= cpu_selection_d;
            cpu_write_q     <= cpu_write_d;
            cpu_data_wr_q   <= cpu_data_wr_d;
            active_q        <= active_d;
            m0_data_rd_q    <= m0_data_rd_d;
            m1_data_rd_q    <= m1_data_rd_d;
            grant_q         <= grant_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (bus.m0_start || bus.m1_start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.cpu_active) begin
                    state_d = BUSY;
                end else if (timer == TIMER_LAST) begin
                    state_d = ABORT;
                end
            end
            BUSY: begin
                if (!bus.cpu_active) begin
                    state_d = DONE;
                end
            end
            ABORT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is registered; this process computes their next values.
    always_comb begin
        owner_d         = owner;
        last_grant_d    = last_grant;
        timer_d         = timer;
        cpu_start_d     = cpu_start_q;
        cpu_address_d   = cpu_address_q;
        cpu_selection_d = cpu_selection_q;
        cpu_write_d     = cpu_write_q;
        cpu_data_wr_d   = cpu_data_wr_q;
        active_d        = active_q;
        m0_data_rd_d    = m0_data_rd_q;
        m1_data_rd_d    = m1_data_rd_q;
        grant_d         = grant_q;
        timeout_err_d   = timeout_err_q;
        unique case (state)
            IDLE: begin
                if (bus.m0_start || bus.m1_start) begin
                    owner_d     = pick;
                    cpu_start_d = 1'b1;
                    timer_d     = '0;
                    if (pick) begin
                        cpu_address_d   = bus.m1_address;
                        cpu_selection_d = bus.m1_selection;
                        cpu_write_d     = bus.m1_write;
                        cpu_data_wr_d   = bus.m1_data_wr;
                        grant_d         = 2'b10;
                    end else begin
                        cpu_address_d   = bus.m0_address;
                        cpu_selection_d = bus.m0_selection;
                        cpu_write_d     = bus.m0_write;
                        cpu_data_wr_d   = bus.m0_data_wr;
                        grant_d         = 2'b01;
                    end
                end
            end
            ISSUE: begin
                if (bus.cpu_active) begin
                    cpu_start_d     = 1'b0;
                    active_d[owner] = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    // Raise active during ABORT so the requester still completes its handshake.
                    cpu_start_d     = 1'b0;
                    timeout_err_d   = 1'b1;
                    active_d[owner] = 1'b1;
                end else begin
                    timer_d = timer + 16'd1;
                end
            end
            BUSY: begin
                if (!bus.cpu_active) begin
                    active_d[owner] = 1'b0;
                    if (owner) begin
                        m1_data_rd_d = bus.cpu_data_rd;
                    end else begin
                        m0_data_rd_d = bus.cpu_data_rd;
                    end
                end
            end
            ABORT: begin
                timeout_err_d   = 1'b0;
                active_d[owner] = 1'b0;
                if (owner) begin
                    m1_data_rd_d = ABORT_DATA;
                end else begin
                    m0_data_rd_d = ABORT_DATA;
                end
            end
            DONE: begin
                last_grant_d = owner;
                grant_d      = '0;
                cpu_write_d  = 1'b0;
            end
            default: begin
                cpu_start_d = 1'b0;
            end
        endcase
    end

    assign bus.cpu_start     = cpu_start_q;
    assign bus.cpu_address   = cpu_address_q;
    assign bus.cpu_selection = cpu_selection_q;
    assign bus.cpu_write     = cpu_write_q;
    assign bus.cpu_data_wr   = cpu_data_wr_q;
    assign bus.m0_active     = active_q[0];
    assign bus.m1_active     = active_q[1];
    assign bus.m0_data_rd    = m0_data_rd_q;
    assign bus.m1_data_rd    = m1_data_rd_q;
    assign bus.grant         = grant_q;
    assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios with literal expectations, then randomized
// requesters and bus responder, all compared every cycle against a transaction-level model.
module tb_cpu_bus_arbiter;
    localparam int          DW  = 32;
    localparam int          AW  = 32;
    localparam int unsigned TMO = 8;
    localparam logic [31:0] ABT = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_arbiter_if #(.dw(DW), .aw(AW)) bus ();

    cpu_bus_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(TMO), .ABORT_DATA(ABT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the phase of the current transaction is read off the expected outputs.
    logic [1:0]  e_grant;
    logic        e_start;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic        e_write;
    logic [31:0] e_wdata;
    logic [1:0]  e_act;
    logic [31:0] e_rd [2];
    logic        e_tmo;
    int          e_owner;
    int          e_last;
    int          e_wait;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        model_live = 1'b1;
        if (!rst) begin
            e_grant = '0; e_start = 1'b0; e_addr = '0; e_sel = '0; e_write = 1'b0;
            e_wdata = '0; e_act = '0; e_rd[0] = '0; e_rd[1] = '0; e_tmo = 1'b0;
            e_owner = 0; e_last = 1; e_wait = 0;
        end else if (e_grant == 2'b00) begin
            if (bus.m0_start || bus.m1_start) begin
                e_owner = (bus.m0_start && bus.m1_start) ? 1 - e_last : (bus.m1_start ? 1 : 0);
                e_addr  = e_owner == 1 ? bus.m1_address   : bus.m0_address;
                e_sel   = e_owner == 1 ? bus.m1_selection : bus.m0_selection;
                e_write = e_owner == 1 ? bus.m1_write     : bus.m0_write;
                e_wdata = e_owner == 1 ? bus.m1_data_wr   : bus.m0_data_wr;
                e_grant = 2'(2'b01 << e_owner);
                e_start = 1'b1;
                e_wait  = 0;
            end
        end else if (e_start) begin
            if (bus.cpu_active) begin
                e_start = 1'b0;
                e_act[e_owner] = 1'b1;
            end else if (e_wait == int'(TMO) - 1) begin
                e_start = 1'b0;
                e_tmo = 1'b1;
                e_act[e_owner] = 1'b1;
            end else begin
                e_wait++;
            end
        end else if (e_tmo) begin
            e_tmo = 1'b0;
            e_act[e_owner] = 1'b0;
            e_rd[e_owner] = ABT;
        end else if (e_act[e_owner]) begin
            if (!bus.cpu_active) begin
                e_act[e_owner] = 1'b0;
                e_rd[e_owner] = bus.cpu_data_rd;
            end
        end else begin
            e_last  = e_owner;
            e_grant = '0;
            e_write = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("grant",         bus.grant,         e_grant);
            check("cpu_start",     bus.cpu_start,     e_start);
            check("cpu_address",   bus.cpu_address,   e_addr);
            check("cpu_selection", bus.cpu_selection, e_sel);
            check("cpu_write",     bus.cpu_write,     e_write);
            check("cpu_data_wr",   bus.cpu_data_wr,   e_wdata);
            check("m0_active",     bus.m0_active,     e_act[0]);
            check("m1_active",     bus.m1_active,     e_act[1]);
            check("m0_data_rd",    bus.m0_data_rd,    e_rd[0]);
            check("m1_data_rd",    bus.m1_data_rd,    e_rd[1]);
            check("timeout_err",   bus.timeout_err,   e_tmo);
        end
    end

    // Bus responder: mode 0 random latency/length (sometimes silent), 1 fixed, 2 never answers.
    int          rsp_mode = 2;
    int          fx_delay = 0;
    int          fx_len   = 1;
    logic [31:0] fx_data  = '0;
    int          r_delay, r_len;
    bit          r_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            r_busy = 1'b0;
            bus.cpu_active  = 1'b0;
            bus.cpu_data_rd = '0;
        end else begin
            bus.cpu_data_rd = (rsp_mode == 1) ? fx_data : $urandom;
            if (!r_busy && bus.cpu_start && rsp_mode != 2) begin
                r_busy = 1'b1;
                if (rsp_mode == 1) begin
                    r_delay = fx_delay; r_len = fx_len;
                end else if ($urandom_range(0, 7) == 0) begin
                    r_delay = int'(TMO) + 2; r_len = 0;
                end else begin
                    r_delay = $urandom_range(0, 3); r_len = $urandom_range(1, 4);
                end
            end
            if (r_busy) begin
                if (r_delay > 0) begin
                    r_delay--; bus.cpu_active = 1'b0;
                end else if (r_len > 0) begin
                    r_len--; bus.cpu_active = 1'b1;
                end else begin
                    r_busy = 1'b0; bus.cpu_active = 1'b0;
                end
            end else begin
                bus.cpu_active = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Requester rule: drop start once active has been seen.
    task automatic handshake();
        if (bus.m0_start && bus.m0_active) bus.m0_start = 1'b0;
        if (bus.m1_start && bus.m1_active) bus.m1_start = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            cyc(1);
            handshake();
            if (!bus.m0_start && !bus.m1_start && bus.grant == 2'b00) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic rand_req(input int r);
        logic       st, act;
        logic [1:0] own;
        own = (r == 0) ? 2'b01 : 2'b10;
        st  = (r == 0) ? bus.m0_start  : bus.m1_start;
        act = (r == 0) ? bus.m0_active : bus.m1_active;
        if (st && act) begin
            st = 1'b0;
        end else if (st && bus.grant != own && $urandom_range(0, 15) == 0) begin
            st = 1'b0;
        end else if (!st && $urandom_range(0, 3) == 0) begin
            st = 1'b1;
            if (r == 0) begin
                bus.m0_address = $urandom; bus.m0_selection = 4'($urandom);
                bus.m0_write = 1'($urandom); bus.m0_data_wr = $urandom;
            end else begin
                bus.m1_address = $urandom; bus.m1_selection = 4'($urandom);
                bus.m1_write = 1'($urandom); bus.m1_data_wr = $urandom;
            end
        end
        if (r == 0) bus.m0_start = st; else bus.m1_start = st;
    endtask

    int         n0, ns, nt, na, g1;
    bit         found, m1_touched;
    logic [1:0] prevg;
    logic [1:0] seq [$];

    initial begin
        bus.m0_start = 1'b0; bus.m0_address = '0; bus.m0_selection = '0;
        bus.m0_write = 1'b0; bus.m0_data_wr = '0;
        bus.m1_start = 1'b0; bus.m1_address = '0; bus.m1_selection = '0;
        bus.m1_write = 1'b0; bus.m1_data_wr = '0;
        rst = 1'b0;
        cyc(3);
        check("rst_grant", bus.grant, 0);
        check("rst_cpu_start", bus.cpu_start, 0);
        check("rst_m0_active", bus.m0_active, 0);
        check("rst_timeout_err", bus.timeout_err, 0);

        // Simultaneous start after reset: m0 read first, then m1 write.
        rst = 1'b1;
        rsp_mode = 1; fx_delay = 1; fx_len = 3; fx_data = 32'hCAFEF00D;
        bus.m0_address = 32'h10; bus.m0_selection = 4'hF; bus.m0_write = 1'b0; bus.m0_start = 1'b1;
        bus.m1_address = 32'h20; bus.m1_selection = 4'hF; bus.m1_write = 1'b1;
        bus.m1_data_wr = 32'h12345678; bus.m1_start = 1'b1;
        cyc(1);
        check("first_grant_m0", bus.grant, 2'b01);
        check("first_cpu_start", bus.cpu_start, 1);
        check("first_cpu_address", bus.cpu_address, 32'h10);
        check("first_cpu_write", bus.cpu_write, 0);
        n0 = 0; m1_touched = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (bus.m0_active) n0++;
            if (bus.m1_active) m1_touched = 1'b1;
            handshake();
            if (n0 > 0 && !bus.m0_active) break;
        end
        check("m0_active_cycles", n0, 3);
        check("m0_read_data", bus.m0_data_rd, 32'hCAFEF00D);
        check("m1_active_untouched", m1_touched, 0);
        check("m1_data_untouched", bus.m1_data_rd, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            handshake();
            if (bus.grant == 2'b10) found = 1'b1;
        end
        check("m1_granted_after_done", found, 1);
        check("m1_cpu_write", bus.cpu_write, 1);
        check("m1_cpu_address", bus.cpu_address, 32'h20);
        check("m1_cpu_data_wr", bus.cpu_data_wr, 32'h12345678);
        drain("drain_after_pair");

        // m1 read that the bus never accepts.
        rsp_mode = 2;
        bus.m1_address = 32'h30; bus.m1_write = 1'b0; bus.m1_start = 1'b1;
        ns = 0; nt = 0; na = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (bus.cpu_start) ns++;
            if (bus.timeout_err) nt++;
            if (bus.m1_active) na++;
            handshake();
        end
        check("abort_cpu_start_cycles", ns, 8);
        check("abort_timeout_pulses", nt, 1);
        check("abort_m1_active_cycles", na, 1);
        check("abort_m1_data", bus.m1_data_rd, 32'hDEADBEEF);
        rsp_mode = 1; fx_delay = 0; fx_len = 1; fx_data = 32'h0BADCAFE;
        bus.m0_address = 32'h40; bus.m0_write = 1'b0; bus.m0_start = 1'b1;
        drain("drain_after_abort");
        check("m0_after_abort_data", bus.m0_data_rd, 32'h0BADCAFE);

        // Reset while m0 is in BUSY.
        fx_len = 6;
        bus.m0_address = 32'h50; bus.m0_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            if (bus.m0_active) found = 1'b1;
        end
        check("busy_reached", found, 1);
        rst = 1'b0; bus.m0_start = 1'b0; bus.m1_start = 1'b0;
        cyc(1);
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_cpu_start", bus.cpu_start, 0);
        check("mid_rst_m0_active", bus.m0_active, 0);
        check("mid_rst_m0_data", bus.m0_data_rd, 0);
        check("mid_rst_m1_data", bus.m1_data_rd, 0);
        check("mid_rst_cpu_address", bus.cpu_address, 0);

        // Both requesting continuously: strict alternation starting with m0.
        rst = 1'b1; fx_len = 1; fx_delay = 0;
        bus.m0_start = 1'b1; bus.m1_start = 1'b1;
        prevg = 2'b00;
        for (int i = 0; i < 100 && seq.size() < 6; i++) begin
            cyc(1);
            if (bus.grant != 2'b00 && prevg == 2'b00) seq.push_back(bus.grant);
            prevg = bus.grant;
        end
        check("rr_count", seq.size(), 6);
        for (int i = 0; i < seq.size(); i++) begin
            check("rr_order", seq[i], (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        bus.m0_start = 1'b0; bus.m1_start = 1'b0;
        drain("drain_after_rr");

        // m1 pulses start only while m0 is busy: never granted.
        fx_len = 4;
        bus.m0_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            handshake();
            if (bus.m0_active) found = 1'b1;
        end
        check("pulse_busy_reached", found, 1);
        bus.m1_start = 1'b1;
        cyc(1);
        bus.m1_start = 1'b0;
        g1 = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            handshake();
            if (bus.grant == 2'b10 || bus.m1_active) g1++;
        end
        check("pulse_not_granted", g1, 0);

        // Randomized traffic with occasional resets.
        rsp_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0; bus.m0_start = 1'b0; bus.m1_start = 1'b0;
            end else begin
                rst = 1'b1;
                rand_req(0);
                rand_req(1);
            end
        end
        rst = 1'b1;
        bus.m0_start = 1'b0; bus.m1_start = 1'b0;
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
